// File: rtl/sel_sequencer_pkg.sv
// Shared encodings and the position-advance rule for the decoder select sequencer.
package sel_sequencer_pkg;

    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PP   = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        dir_e             dir;
        logic             wrap;
    } adv_t;

    // Next position for one advance; hold returns the inputs unchanged.
    function automatic adv_t next_pos(input logic [SEL_W-1:0] sel, input mode_e mode,
                                      input dir_e dir);
        adv_t res;
        res.sel  = sel;
        res.dir  = dir;
        res.wrap = 1'b0;
        case (mode)
            MODE_UP: begin
                res.sel  = sel + 3'd1;
                res.wrap = (sel == 3'd7);
            end
            MODE_DOWN: begin
                res.sel  = sel - 3'd1;
                res.wrap = (sel == 3'd0);
            end
            MODE_PP: begin
                if (dir == DIR_UP) begin
                    if (sel == 3'd7) begin
                        res.sel  = 3'd6;
                        res.dir  = DIR_DOWN;
                        res.wrap = 1'b1;
                    end else begin
                        res.sel = sel + 3'd1;
                    end
                end else begin
                    if (sel == 3'd0) begin
                        res.sel  = 3'd1;
                        res.dir  = DIR_UP;
                        res.wrap = 1'b1;
                    end else begin
                        res.sel = sel - 3'd1;
                    end
                end
            end
            default: ;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sel_sequencer_tick_prescaler.sv
// Rate divider: counts 0..PRESCALE-1 while enabled and flags the terminal count.
module tick_prescaler #(
    parameter int PRESCALE = 4,
    parameter int PS_W     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [PS_W-1:0] TC_VAL = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] cnt_q, cnt_d;

    assign tc = en && (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || !en || tc) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sel_sequencer.sv
// Registered 3-bit position sequencer (up/down/ping-pong/hold) feeding a one-hot decoder.
module sel_sequencer
    import sel_sequencer_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int PS_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [SEL_W-1:0] sel,
    output logic             tick,
    output logic             wrap,
    output logic             running
);

    state_e           state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             ps_clr, ps_tc, adv;
    adv_t             nxt;

    tick_prescaler #(.PRESCALE(PRESCALE), .PS_W(PS_W)) u_ps (
        .clk (clk),
        .rst (rst),
        .en  (state_q == ST_RUN),
        .clr (ps_clr),
        .tc  (ps_tc)
    );

    assign nxt = next_pos(sel_q, mode_e'(mode), dir_q);

    always_comb begin
        state_d = state_q;
        if (stop)       state_d = ST_IDLE;
        else if (start) state_d = ST_RUN;

        ps_clr = (state_d != state_q) || load;
        // A stop on the terminal-count edge freezes sel rather than advancing.
        adv = (state_q == ST_RUN) ? (ps_tc && state_d == ST_RUN) : step;

        sel_d  = sel_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (load) begin
            sel_d = load_val;
            dir_d = DIR_UP;
        end else if (adv && mode_e'(mode) != MODE_HOLD) begin
            sel_d  = nxt.sel;
            dir_d  = nxt.dir;
            tick_d = 1'b1;
            wrap_d = nxt.wrap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_UP;
            sel_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign sel     = sel_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;
    assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_sel_sequencer.sv
// Directed plus random bench for sel_sequencer against an integer reference model.
module tb_sel_sequencer;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst, start, stop, step, load;
    logic [2:0] load_val;
    logic [1:0] mode;
    logic [2:0] sel;
    logic       tick, wrap, running;

    sel_sequencer #(.PRESCALE(P), .PS_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .load(load),
        .load_val(load_val), .mode(mode), .sel(sel), .tick(tick), .wrap(wrap),
        .running(running)
    );

    always #5 clk = ~clk;

    // Reference model: position, direction (+1/-1), period count, run flag.
    int m_sel, m_dir, m_pc, m_run, m_tick, m_wrap;
    int n_chk = 0, n_fail = 0;

    task automatic model_reset();
        m_sel = 0; m_dir = 1; m_pc = 0; m_run = 0; m_tick = 0; m_wrap = 0;
    endtask

    task automatic model_step();
        int nrun, adv;
        nrun = stop ? 0 : (start ? 1 : m_run);
        m_tick = 0; m_wrap = 0;
        if (m_run == 1) adv = (m_pc == P - 1) && nrun == 1;
        else            adv = step;
        if (load || nrun != m_run || m_run == 0 || m_pc == P - 1) m_pc = 0;
        else m_pc = m_pc + 1;
        if (load) begin
            m_sel = int'(load_val); m_dir = 1;
        end else if (adv != 0 && mode != 2'b11) begin
            m_tick = 1;
            case (mode)
                2'b00: begin m_wrap = (m_sel == 7); m_sel = (m_sel + 1) % 8; end
                2'b01: begin m_wrap = (m_sel == 0); m_sel = (m_sel + 7) % 8; end
                default: begin
                    if (m_dir == 1 && m_sel == 7)      begin m_sel = 6; m_dir = -1; m_wrap = 1; end
                    else if (m_dir == -1 && m_sel == 0) begin m_sel = 1; m_dir = 1; m_wrap = 1; end
                    else m_sel = m_sel + m_dir;
                end
            endcase
        end
        m_run = nrun;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sel"}, int'(sel), m_sel);
        chk({tag, ".tick"}, int'(tick), m_tick);
        chk({tag, ".wrap"}, int'(wrap), m_wrap);
        chk({tag, ".running"}, int'(running), m_run);
    endtask

    task automatic cyc(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        start = 0; stop = 0; step = 0; load = 0;
    endtask

    // Run until the model has just advanced to position s; bounded.
    task automatic run_to(input int s, input string tag);
        int budget = 200;
        do begin
            cyc(tag);
            budget--;
        end while (!(m_tick == 1 && m_sel == s) && budget > 0);
        if (budget == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s: timeout waiting for sel=%0d", tag, s);
        end
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; step = 0; load = 0; load_val = 0; mode = 0;
        model_reset();
        #17;
        check_all("reset");
        @(negedge clk);
        rst = 0;

        // Count up through a full wrap.
        mode = 2'b00; start = 1;
        cyc("start_up");
        repeat (40) cyc("up");
        stop = 1; cyc("stop_up");

        // Step down from 0 in IDLE.
        load = 1; load_val = 3'd0; cyc("load0");
        mode = 2'b01;
        step = 1; cyc("step_a");
        chk("step_first", int'(sel), 7); chk("step_first_wrap", int'(wrap), 1);
        step = 1; cyc("step_b");
        step = 1; cyc("step_c");
        chk("step_last", int'(sel), 5); chk("step_running", int'(running), 0);
        cyc("step_tail");

        // Ping-pong from 5 while running.
        mode = 2'b10; load = 1; load_val = 3'd5; start = 1;
        cyc("pp_start");
        repeat (64) cyc("pp");

        // Stop two cycles into a period at sel=3, restart later.
        mode = 2'b00;
        run_to(3, "to3");
        cyc("mid1");
        stop = 1; cyc("mid_stop");
        repeat (10) cyc("stopped");
        chk("stop_hold", int'(sel), 3);
        start = 1; cyc("restart");
        repeat (3) cyc("restart_wait");
        chk("restart_pre", int'(sel), 3);
        cyc("restart_adv");
        chk("restart_sel", int'(sel), 4); chk("restart_tick", int'(tick), 1);

        // Load colliding with a terminal count at sel=6.
        run_to(6, "to6");
        repeat (3) cyc("pre_tc");
        load = 1; load_val = 3'd2; cyc("load_tc");
        chk("load_tc_sel", int'(sel), 2); chk("load_tc_tick", int'(tick), 0);
        repeat (3) cyc("post_load");
        cyc("post_load_adv");
        chk("post_load_sel", int'(sel), 3); chk("post_load_tick", int'(tick), 1);

        // Hold then async reset mid-run at sel=5.
        mode = 2'b11; repeat (9) cyc("hold");
        mode = 2'b00;
        run_to(5, "to5");
        #2 rst = 1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 0;
        mode = 2'b10; start = 1;
        cyc("resume");
        repeat (12) cyc("resume_run");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            start    = ($urandom_range(0, 15) == 0);
            stop     = ($urandom_range(0, 19) == 0);
            step     = ($urandom_range(0, 3) == 0);
            load     = ($urandom_range(0, 24) == 0);
            load_val = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            cyc("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
